// File: rtl/de4_qsys_sysid_pkg.sv
// -----------------------------------------------------------------------------
// de4_qsys_sysid_pkg
// Shared definitions for the system-ID checker: FSM state encoding, register
// offsets inside the sysid slave and the default expected ID/timestamp words.
// No ports (package).
// -----------------------------------------------------------------------------
package de4_qsys_sysid_pkg;

   // State encoding kept as plain constants so the value seen on a logic
   // analyser matches the source directly.
   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_REQ_ID = 3'd1;   // issuing read of the ID word
   localparam state_t S_RSP_ID = 3'd2;   // waiting for the ID response
   localparam state_t S_REQ_TS = 3'd3;   // issuing read of the timestamp word
   localparam state_t S_RSP_TS = 3'd4;   // waiting for the timestamp response
   localparam state_t S_SETTLE = 3'd5;   // timestamp captured, compare in flight
   localparam state_t S_CMP    = 3'd6;   // both compares registered, fold into pass
   localparam state_t S_DONE   = 3'd7;

   localparam logic [31:0] SYSID_ID_OFS = 32'h0000_0000;
   localparam logic [31:0] SYSID_TS_OFS = 32'h0000_0004;

   localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] DEF_EXPECTED_TS = 32'h557A_E4CA;   // 1434117322

   // True in the four states that own a bus transfer phase and therefore
   // run the timeout counter.
   function automatic logic is_xfer_state(input state_t s);
      return (s == S_REQ_ID) || (s == S_RSP_ID) || (s == S_REQ_TS) || (s == S_RSP_TS);
   endfunction

endpackage

// File: rtl/de4_qsys_timeout_cnt.sv
// -----------------------------------------------------------------------------
// de4_qsys_timeout_cnt
// Per-phase watchdog. Counts cycles while enabled; o_expired is high during the
// TIMEOUT_CYC-th enabled cycle since the last clear, so a phase lasts at most
// TIMEOUT_CYC cycles.
// Ports:
//   i_clock    system clock
//   i_reset    synchronous active-high reset
//   i_clear    restart the count (phase entry)
//   i_enable   count this cycle
//   o_expired  last allowed cycle of the phase
// -----------------------------------------------------------------------------
module de4_qsys_timeout_cnt #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/de4_qsys_sysid_checker.sv
// -----------------------------------------------------------------------------
// de4_qsys_sysid_checker
// Avalon-MM read master that reads the sysid slave's ID word (BASE+0) and
// timestamp word (BASE+4) after a start pulse and compares them against the
// expected build values, so boot logic can reject a mismatched
// bitstream/software pairing early.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 one-cycle pulse, ignored while busy
//   busy                  check in progress
//   done                  check finished, held until next start/reset
//   pass                  id_ok & ts_ok & !timeout, valid with done
//   id_ok, ts_ok          individual 32-bit compare results
//   timeout               a transfer was abandoned
//   read_id, read_ts      captured readdata (0 if never received)
//   avm_*                 Avalon-MM read master interface
// -----------------------------------------------------------------------------
module de4_qsys_sysid_checker
   import de4_qsys_sysid_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter logic [31:0]       EXPECTED_ID = DEF_EXPECTED_ID,
   parameter logic [31:0]       EXPECTED_TS = DEF_EXPECTED_TS,
   parameter int                TIMEOUT_CYC = 1024,
   parameter int                MAX_RETRIES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              id_ok,
   output logic              ts_ok,
   output logic              timeout,
   output logic [31:0]       read_id,
   output logic [31:0]       read_ts,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid
);

   localparam int            RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [RTY_W-1:0] MAX_RTY = RTY_W'(MAX_RETRIES);

   localparam logic [ADDR_W-1:0] ADDR_ID = BASE_ADDR + ADDR_W'(SYSID_ID_OFS);
   localparam logic [ADDR_W-1:0] ADDR_TS = BASE_ADDR + ADDR_W'(SYSID_TS_OFS);

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             r_id_ok;
   logic             r_ts_ok;
   logic             r_timeout;
   logic [31:0]      r_read_id;
   logic [31:0]      r_read_ts;
   logic             r_id_vld;     // r_read_id holds a real response
   logic             r_ts_vld;
   logic [RTY_W-1:0] r_retries;    // shared by both words within one check

   state_t w_state_nxt;
   logic   w_start_go;
   logic   w_accept;
   logic   w_cap_id;
   logic   w_cap_ts;
   logic   w_retry;
   logic   w_tmo_set;
   logic   w_expired;
   logic   w_enter_done;
   logic   w_can_retry;

   // Bus outputs are a pure decode of the registered state, so address and
   // read stay stable for the whole waitrequest stall.
   assign avm_read    = (r_state == S_REQ_ID) || (r_state == S_REQ_TS);
   assign avm_address = ((r_state == S_REQ_TS) || (r_state == S_RSP_TS)) ? ADDR_TS : ADDR_ID;

   assign w_accept     = avm_read && !avm_waitrequest;
   assign w_start_go   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_can_retry  = (r_retries < MAX_RTY);
   assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

   de4_qsys_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_cnt (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_clear   (w_state_nxt != r_state),   // every phase entry, including a retry
      .i_enable  (is_xfer_state(r_state)),
      .o_expired (w_expired)
   );

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cap_id    = 1'b0;
      w_cap_ts    = 1'b0;
      w_retry     = 1'b0;
      w_tmo_set   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_state_nxt = S_REQ_ID;
         end
         S_REQ_ID: begin
            if (w_accept) begin
               if (avm_readdatavalid) begin
                  // Zero-latency slave: data comes with the accept.
                  w_cap_id    = 1'b1;
                  w_state_nxt = S_REQ_TS;
               end else begin
                  w_state_nxt = S_RSP_ID;
               end
            end else if (w_expired) begin
               // A request never accepted means a hung interconnect; retrying
               // would only hide it.
               w_tmo_set   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_RSP_ID: begin
            if (avm_readdatavalid) begin
               w_cap_id    = 1'b1;
               w_state_nxt = S_REQ_TS;
            end else if (w_expired) begin
               if (w_can_retry) begin
                  w_retry     = 1'b1;
                  w_state_nxt = S_REQ_ID;
               end else begin
                  w_tmo_set   = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_REQ_TS: begin
            if (w_accept) begin
               if (avm_readdatavalid) begin
                  w_cap_ts    = 1'b1;
                  w_state_nxt = S_SETTLE;
               end else begin
                  w_state_nxt = S_RSP_TS;
               end
            end else if (w_expired) begin
               w_tmo_set   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_RSP_TS: begin
            if (avm_readdatavalid) begin
               w_cap_ts    = 1'b1;
               w_state_nxt = S_SETTLE;
            end else if (w_expired) begin
               if (w_can_retry) begin
                  w_retry     = 1'b1;
                  w_state_nxt = S_REQ_TS;
               end else begin
                  w_tmo_set   = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_SETTLE: w_state_nxt = S_CMP;    // ts_ok registers this cycle
         S_CMP:    w_state_nxt = S_DONE;   // pass folds the registered flags
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_id_ok   <= 1'b0;
         r_ts_ok   <= 1'b0;
         r_timeout <= 1'b0;
         r_read_id <= '0;
         r_read_ts <= '0;
         r_id_vld  <= 1'b0;
         r_ts_vld  <= 1'b0;
         r_retries <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_go) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_timeout <= 1'b0;
            r_read_id <= '0;
            r_read_ts <= '0;
            r_id_vld  <= 1'b0;
            r_ts_vld  <= 1'b0;
            r_retries <= '0;
         end else begin
            if (w_cap_id) begin
               r_read_id <= avm_readdata;
               r_id_vld  <= 1'b1;
            end
            if (w_cap_ts) begin
               r_read_ts <= avm_readdata;
               r_ts_vld  <= 1'b1;
            end
            // Compare from the captured register one cycle after capture,
            // keeping the 32-bit comparator off the readdata input path.
            r_id_ok <= r_id_vld && (r_read_id == EXPECTED_ID);
            r_ts_ok <= r_ts_vld && (r_read_ts == EXPECTED_TS);
            if (w_retry)   r_retries <= r_retries + RTY_W'(1);
            if (w_tmo_set) r_timeout <= 1'b1;
            if (w_enter_done) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= !w_tmo_set && r_id_ok && r_ts_ok;
            end
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign id_ok   = r_id_ok;
   assign ts_ok   = r_ts_ok;
   assign timeout = r_timeout;
   assign read_id = r_read_id;
   assign read_ts = r_read_ts;

endmodule
